keypad_letter_entry: RTL and testbench

KEYPAD_LETTER_ENTRY -- requirements
Module: keypad_letter_entry

---
 rtl/keypad_pkg.sv | 73 +++++++
 rtl/keypad_letter_entry_scan.sv | 96 +++++++++
 rtl/keypad_letter_entry.sv | 167 ++++++++++++++++
 tb/tb_keypad_letter_entry.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and tables for the 4x4 multi-tap letter keypad.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    // Key code is {row index, column index}, with R0/C0 as index 0.
    typedef enum logic [3:0] {
        K_R0C0 = 4'd0,  K_R0C1 = 4'd1,  K_R0C2 = 4'd2,  K_R0C3 = 4'd3,
        K_R1C0 = 4'd4,  K_R1C1 = 4'd5,  K_R1C2 = 4'd6,  K_R1C3 = 4'd7,
        K_R2C0 = 4'd8,  K_R2C1 = 4'd9,  K_R2C2 = 4'd10, K_R2C3 = 4'd11,
        K_R3C0 = 4'd12, K_R3C1 = 4'd13, K_R3C2 = 4'd14, K_R3C3 = 4'd15
    } key_code_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CYCLING = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_LETTER = 2'd1,
        ACT_SUBMIT = 2'd2,
        ACT_CLEAR  = 2'd3
    } key_action_t;

    typedef struct packed {
        key_action_t action;
        logic [7:0]  base;
        logic [2:0]  count;
    } key_info_t;

    localparam logic [7:0] C_ASCII_SPACE = 8'h20;
    localparam logic [7:0] C_ASCII_NUL   = 8'h00;

    // Letter table: first letter of each key and how many letters it carries.
    function automatic key_info_t key_lookup(input key_code_t k);
        key_info_t info;
        info = '{action: ACT_NONE, base: C_ASCII_SPACE, count: 3'd1};
        case (k)
            K_R0C1:  info = '{action: ACT_LETTER, base: 8'h41, count: 3'd3};
            K_R0C2:  info = '{action: ACT_LETTER, base: 8'h44, count: 3'd3};
            K_R1C0:  info = '{action: ACT_LETTER, base: 8'h47, count: 3'd3};
            K_R1C1:  info = '{action: ACT_LETTER, base: 8'h4A, count: 3'd3};
            K_R1C2:  info = '{action: ACT_LETTER, base: 8'h4D, count: 3'd3};
            K_R2C0:  info = '{action: ACT_LETTER, base: 8'h50, count: 3'd4};
            K_R2C1:  info = '{action: ACT_LETTER, base: 8'h54, count: 3'd3};
            K_R2C2:  info = '{action: ACT_LETTER, base: 8'h57, count: 3'd4};
            K_R3C0:  info = '{action: ACT_SUBMIT, base: C_ASCII_SPACE, count: 3'd1};
            K_R3C2:  info = '{action: ACT_CLEAR,  base: C_ASCII_SPACE, count: 3'd1};
            default: info = '{action: ACT_NONE,   base: C_ASCII_SPACE, count: 3'd1};
        endcase
        return info;
    endfunction

    // Bit 3 is line 0, bit 0 is line 3 on both rows and columns.
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_letter_entry_scan.sv
// ============================================================================
// Module   : keypad_scan
// Purpose  : Column scanner and press/release debouncer producing key events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic       o_key_event,
    output logic [3:0] o_key_code,
    output logic       o_key_held
);

    localparam int C_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int C_SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam logic [C_DB_W-1:0]   C_DB_ONE    = C_DB_W'(1);
    localparam logic [C_DB_W-1:0]   C_DB_TARGET = C_DB_W'(DEBOUNCE_CYCLES);
    localparam logic [C_SCAN_W-1:0] C_SCAN_LAST = C_SCAN_W'(SCAN_CYCLES - 1);

    logic [3:0]          r_col;
    logic [C_SCAN_W-1:0] r_scan_cnt;
    logic [3:0]          r_last_row;
    logic [C_DB_W-1:0]   r_db_cnt;
    logic                r_held;
    logic                r_event;
    logic [3:0]          r_code;

    logic                w_row_onehot;
    logic [C_DB_W-1:0]   w_db_next;
    logic                w_db_done;
    logic                w_scan_run;

    // While released, count consecutive identical one-hot samples; while
    // held, count consecutive all-zero samples. Anything else restarts.
    always_comb begin
        w_row_onehot = (i_row != 4'd0) && ((i_row & (i_row - 4'd1)) == 4'd0);
        w_db_next    = '0;
        if (r_held) begin
            w_db_next = (i_row == 4'd0) ? (r_db_cnt + C_DB_ONE) : '0;
        end else if (w_row_onehot && (i_row == r_last_row)) begin
            w_db_next = r_db_cnt + C_DB_ONE;
        end else begin
            w_db_next = w_row_onehot ? C_DB_ONE : '0;
        end
        w_db_done  = (w_db_next == C_DB_TARGET);
        w_scan_run = !r_held && (i_row == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= 4'b1000;
            r_scan_cnt <= '0;
            r_last_row <= 4'd0;
            r_db_cnt   <= '0;
            r_held     <= 1'b0;
            r_event    <= 1'b0;
            r_code     <= 4'd0;
        end else begin
            r_last_row <= i_row;
            r_event    <= 1'b0;
            r_db_cnt   <= w_db_done ? '0 : w_db_next;
            if (w_db_done) begin
                r_held <= ~r_held;
                if (!r_held) begin
                    r_event <= 1'b1;
                    r_code  <= {onehot_index(i_row), onehot_index(r_col)};
                end
            end
            if (w_scan_run) begin
                if (r_scan_cnt == C_SCAN_LAST) begin
                    r_scan_cnt <= '0;
                    r_col      <= {r_col[0], r_col[3:1]};
                end else begin
                    r_scan_cnt <= r_scan_cnt + C_SCAN_W'(1);
                end
            end
        end
    end

    assign o_col       = r_col;
    assign o_key_event = r_event;
    assign o_key_code  = r_code;
    assign o_key_held  = r_held;

endmodule

`default_nettype wire

// File: rtl/keypad_letter_entry.sv
// ============================================================================
// Module   : keypad_letter_entry
// Purpose  : Multi-tap letter entry on a scanned 4x4 keypad.
//            Optional idle auto-commit enabled by defining KEYPAD_AUTOCOMMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_letter_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] pending,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       submit,
    output logic       clear
);

    logic       w_key_event;
    logic [3:0] w_key_code;
    logic       w_key_held;
    logic       w_timeout;

    keypad_scan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SCAN_CYCLES     (SCAN_CYCLES)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_row       (row),
        .o_col       (col),
        .o_key_event (w_key_event),
        .o_key_code  (w_key_code),
        .o_key_held  (w_key_held)
    );

    state_t     r_state,   w_state_n;
    logic [3:0] r_key,     w_key_n;
    logic [1:0] r_tap,     w_tap_n;
    logic [7:0] r_pending, w_pending_n;
    logic [7:0] r_letter,  w_letter_n;
    logic       r_letter_valid, w_letter_valid_n;
    logic       r_submit,  w_submit_n;
    logic       r_clear,   w_clear_n;
    key_info_t  w_info;
    logic [1:0] w_tap_inc;

`ifdef KEYPAD_AUTOCOMMIT_EN
    localparam int C_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT_CYCLES - 1);

    logic [C_TMR_W-1:0] r_idle_cnt;

    // Counts debounced-idle cycles while a letter is pending.
    assign w_timeout = (r_state == ST_CYCLING) && !w_key_held && (r_idle_cnt == C_TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state == ST_CYCLING) && !w_key_held && !w_key_event && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + C_TMR_W'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = w_key_held ^ (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_n        = r_state;
        w_key_n          = r_key;
        w_tap_n          = r_tap;
        w_pending_n      = r_pending;
        w_letter_n       = r_letter;
        w_letter_valid_n = 1'b0;
        w_submit_n       = 1'b0;
        w_clear_n        = 1'b0;
        w_info           = key_lookup(key_code_t'(w_key_code));
        w_tap_inc        = r_tap + 2'd1;

        if (w_key_event) begin
            case (w_info.action)
                ACT_LETTER: begin
                    if ((r_state == ST_CYCLING) && (r_key == w_key_code)) begin
                        w_tap_n = ({1'b0, w_tap_inc} == w_info.count) ? 2'd0 : w_tap_inc;
                    end else begin
                        // A different key finalises the old letter first.
                        if (r_state == ST_CYCLING) begin
                            w_letter_n       = r_pending;
                            w_letter_valid_n = 1'b1;
                        end
                        w_key_n   = w_key_code;
                        w_tap_n   = 2'd0;
                        w_state_n = ST_CYCLING;
                    end
                    w_pending_n = w_info.base + {6'd0, w_tap_n};
                end
                ACT_SUBMIT: begin
                    if (r_state == ST_CYCLING) begin
                        w_letter_n       = r_pending;
                        w_letter_valid_n = 1'b1;
                    end
                    w_submit_n  = 1'b1;
                    w_state_n   = ST_IDLE;
                    w_pending_n = C_ASCII_SPACE;
                end
                ACT_CLEAR: begin
                    if (r_state == ST_CYCLING) begin
                        w_state_n   = ST_IDLE;
                        w_pending_n = C_ASCII_SPACE;
                    end else begin
                        w_clear_n = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end else if (w_timeout) begin
            w_letter_n       = r_pending;
            w_letter_valid_n = 1'b1;
            w_state_n        = ST_IDLE;
            w_pending_n      = C_ASCII_SPACE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_key          <= 4'd0;
            r_tap          <= 2'd0;
            r_pending      <= C_ASCII_SPACE;
            r_letter       <= C_ASCII_NUL;
            r_letter_valid <= 1'b0;
            r_submit       <= 1'b0;
            r_clear        <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_key          <= w_key_n;
            r_tap          <= w_tap_n;
            r_pending      <= w_pending_n;
            r_letter       <= w_letter_n;
            r_letter_valid <= w_letter_valid_n;
            r_submit       <= w_submit_n;
            r_clear        <= w_clear_n;
        end
    end

    assign pending      = r_pending;
    assign letter       = r_letter;
    assign letter_valid = r_letter_valid;
    assign submit       = r_submit;
    assign clear        = r_clear;

endmodule

`default_nettype wire

// File: tb/tb_keypad_letter_entry.sv
// ============================================================================
// Module   : tb_keypad_letter_entry
// Purpose  : Self-checking bench for keypad_letter_entry (multi-tap model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_letter_entry;

    localparam int DEB  = 4;
    localparam int SCAN = 2;
    localparam int TMO  = 50;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] pending;
    logic [7:0] letter;
    logic       letter_valid;
    logic       submit;
    logic       clear;

    keypad_letter_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_CYCLES     (SCAN),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .row          (row),
        .col          (col),
        .pending      (pending),
        .letter       (letter),
        .letter_valid (letter_valid),
        .submit       (submit),
        .clear        (clear)
    );

    always #5 tb_clk = ~tb_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe record per cycle: {letter_valid, submit, clear, letter-if-valid}.
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];

    string      groups[16];
    bit         m_cyc;
    int         m_key;
    int         m_tap;
    logic [7:0] m_pend;
    logic [7:0] m_letter;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge tb_clk) begin
        if (letter_valid || submit || clear)
            obs_q.push_back({letter_valid, submit, clear, letter_valid ? letter : 8'h00});
    end

    task automatic model_reset();
        m_cyc    = 1'b0;
        m_key    = -1;
        m_tap    = 0;
        m_pend   = 8'h20;
        m_letter = 8'h00;
    endtask

    task automatic model_commit(input logic sub);
        exp_q.push_back({1'b1, sub, 1'b0, m_pend});
        m_letter = m_pend;
    endtask

    task automatic model_key(input int idx);
        if (groups[idx].len() > 0) begin
            if (m_cyc && m_key == idx) begin
                m_tap = (m_tap + 1) % groups[idx].len();
            end else begin
                if (m_cyc) model_commit(1'b0);
                m_key = idx;
                m_tap = 0;
                m_cyc = 1'b1;
            end
            m_pend = groups[idx][m_tap];
        end else if (idx == 12) begin
            if (m_cyc) model_commit(1'b1);
            else       exp_q.push_back({3'b010, 8'h00});
            m_cyc  = 1'b0;
            m_pend = 8'h20;
        end else if (idx == 14) begin
            if (m_cyc) begin
                m_cyc  = 1'b0;
                m_pend = 8'h20;
            end else begin
                exp_q.push_back({3'b001, 8'h00});
            end
        end
    endtask

    task automatic verify(input string tag);
        check_value({tag, "_pending"}, {24'd0, pending}, {24'd0, m_pend});
        check_value({tag, "_letter"},  {24'd0, letter},  {24'd0, m_letter});
        check_value({tag, "_evt_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_value({tag, "_evt"}, {21'd0, obs_q[i]}, {21'd0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_col(input logic [3:0] tgt);
        bit found;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge tb_clk);
            if (col == tgt) found = 1'b1;
        end
        if (!found) check_value("col_wait", {28'd0, col}, {28'd0, tgt});
    endtask

    task automatic press(input int r, input int c, input string tag);
        logic [3:0] tgt;
        tgt = 4'(4'b1000 >> c);
        wait_col(tgt);
        row = 4'(4'b1000 >> r);
        repeat ($urandom_range(9, 5)) @(negedge tb_clk);
        check_value({tag, "_col_freeze"}, {28'd0, col}, {28'd0, tgt});
        row = 4'd0;
        repeat ($urandom_range(10, 6)) @(negedge tb_clk);
        model_key(r * 4 + c);
        verify(tag);
    endtask

    initial begin
        logic [3:0] c0;
        logic [3:0] c_exp;
        bit         seen;
        int         waited;

        groups[1] = "ABC";  groups[2] = "DEF";  groups[4] = "GHI";
        groups[5] = "JKL";  groups[6] = "MNO";  groups[8] = "PQRS";
        groups[9] = "TUV";  groups[10] = "WXYZ";

        rst = 1'b1;
        row = 4'd0;
        repeat (3) @(negedge tb_clk);
        check_value("rst_col",     {28'd0, col}, 32'h8);
        check_value("rst_pending", {24'd0, pending}, 32'h20);
        check_value("rst_letter",  {24'd0, letter}, 32'h0);
        check_value("rst_strobes", {29'd0, letter_valid, submit, clear}, 32'h0);
        rst = 1'b0;
        model_reset();

        // Idle scan: rotates C0->C1->C2->C3 every SCAN cycles.
        c0 = col;
        for (int w = 0; w < 10 && col == c0; w++) @(negedge tb_clk);
        c0 = col;
        for (int k = 1; k <= 4; k++) begin
            repeat (SCAN) @(negedge tb_clk);
            c_exp = {c0[0], c0[3:1]};
            check_value("scan_rotate", {28'd0, col}, {28'd0, c_exp});
            c0 = c_exp;
        end

        press(0, 1, "a_key");
        press(3, 0, "a_submit");

        for (int i = 0; i < 5; i++) press(2, 0, "pqrs_tap");
        press(3, 0, "pqrs_submit");

        for (int i = 0; i < 3; i++) press(1, 1, "jkl_tap");
        press(0, 2, "switch_key");
        press(1, 0, "ghi_tap");
        press(1, 0, "ghi_tap");
        press(3, 2, "clear_cycling");
        press(3, 2, "clear_idle");

        // Short glitch and multi-bit rows while cycling must not register.
        press(1, 2, "pre_glitch");
        row = 4'b1000;
        repeat (2) @(negedge tb_clk);
        row = 4'd0;
        repeat (10) @(negedge tb_clk);
        verify("glitch");
        row = 4'b1110;
        repeat (10) @(negedge tb_clk);
        row = 4'd0;
        repeat (10) @(negedge tb_clk);
        verify("multibit");

        for (int i = 0; i < 30; i++)
            press($urandom_range(3, 0), $urandom_range(3, 0), "random");

        // Reset mid-press while cycling; the held key then needs full debounce.
        press(1, 0, "pre_reset");
        wait_col(4'b1000);
        row = 4'b0100;
        repeat (2) @(negedge tb_clk);
        rst = 1'b1;
        repeat (2) @(negedge tb_clk);
        check_value("reset_pending", {24'd0, pending}, 32'h20);
        check_value("reset_letter",  {24'd0, letter}, 32'h0);
        rst = 1'b0;
        model_reset();
        obs_q.delete();
        exp_q.delete();
        repeat (2) @(negedge tb_clk);
        check_value("post_reset_early", {24'd0, pending}, 32'h20);
        repeat (8) @(negedge tb_clk);
        row = 4'd0;
        repeat (8) @(negedge tb_clk);
        model_key(4);
        verify("post_reset_held");
        press(3, 0, "post_reset_submit");

        press(2, 1, "t_key");
`ifdef KEYPAD_AUTOCOMMIT_EN
        seen   = 1'b0;
        waited = 0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge tb_clk);
            waited = w;
            if (letter_valid) seen = 1'b1;
        end
        check_value("autocommit_seen", {31'd0, seen}, 32'd1);
        check_value("autocommit_window", {31'd0, (waited >= 30 && waited <= 60)}, 32'd1);
        model_commit(1'b0);
        m_cyc  = 1'b0;
        m_pend = 8'h20;
        verify("autocommit");
`else
        seen   = 1'b0;
        waited = 0;
        repeat (100) @(negedge tb_clk);
        verify("no_autocommit");
        press(3, 0, "t_submit");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
